// File: rtl/conv_2d_3x3.sv
// Streaming 3x3 int8 convolution: COL output channels x TILE_LEN output pixels per tile.
// Optional macro CONV2D_3X3_RELU_EN clamps emitted sums at zero.
module conv_2d_3x3 #(
    parameter int COL           = 4,
    parameter int WGT_WIDTH     = 24,
    parameter int IFM_WIDTH     = 80,
    parameter int OFM_WIDTH     = 24,
    parameter int RF_AWIDTH     = 4,
    parameter int TILE_LEN      = 8,
    parameter int CHN_WIDTH     = 8,
    parameter int CHN_OFT_WIDTH = 6,
    parameter int FMS_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHN_WIDTH-1:0]        cfg_ci,
    input  logic [CHN_WIDTH-1:0]        cfg_co,
    input  logic                        cfg_stride,
    input  logic                        cfg_group,
    input  logic [FMS_WIDTH-1:0]        cfg_ifm_size,
    input  logic                        start_conv,
    input  logic [IFM_WIDTH-1:0]        ifm_group,
    input  logic [WGT_WIDTH-1:0]        wgt_group,
    output logic                        ifm_read_out,
    output logic                        wgt_read,
    output logic                        conv_done,
    output logic [COL-1:0]              sum_valid,
    output logic signed [OFM_WIDTH-1:0] sum [COL]
);
    localparam int RF_DEPTH = 2 ** RF_AWIDTH;
    localparam int IW       = $clog2(TILE_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_I, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CHN_WIDTH-1:0]     c_q, c_d, last_c_q, last_c_d;
    logic [CHN_OFT_WIDTH-1:0] g_q, g_d, last_g_q, last_g_d;
    logic [FMS_WIDTH-1:0]     r_q, r_d, last_r_q, last_r_d;
    logic [FMS_WIDTH-1:0]     s_q, s_d, last_s_q, last_s_d;
    logic                     stride_q, stride_d;
    logic [RF_AWIDTH-1:0]     w_cnt_q, w_cnt_d;
    logic [1:0]               ky_q, ky_d;
    logic [IW-1:0]            d_q, d_d;
    logic                     wgt_read_q, wgt_read_d;
    logic                     ifm_read_q, ifm_read_d;
    logic                     done_q, done_d;
    logic                     valid_q, valid_d;
    logic                     drain_last;
    logic [IW-1:0]            drain_idx;
    logic [WGT_WIDTH-1:0]     rf_q [RF_DEPTH];
    logic [WGT_WIDTH-1:0]     rf_d [RF_DEPTH];

    // One kernel row against TILE_LEN+2 pixels, producing the contribution for output pixel x.
    function automatic logic signed [OFM_WIDTH-1:0] row_mac(
        input logic [IFM_WIDTH-1:0] px,
        input logic [WGT_WIDTH-1:0] w,
        input int                   x
    );
        logic signed [OFM_WIDTH-1:0] acc;
        logic signed [15:0]          a;
        logic signed [15:0]          b;
        logic signed [15:0]          p;
        acc = '0;
        for (int kx = 0; kx < 3; kx++) begin
            a   = {{8{px[(x+kx)*8+7]}}, px[(x+kx)*8 +: 8]};
            b   = {{8{w[kx*8+7]}}, w[kx*8 +: 8]};
            p   = a * b;
            acc = acc + {{(OFM_WIDTH-16){p[15]}}, p};
        end
        return acc;
    endfunction

    assign drain_last = (d_q == (stride_q ? IW'(TILE_LEN/2 - 1) : IW'(TILE_LEN - 1)));
    assign drain_idx  = stride_q ? IW'(int'(d_q) * 2) : d_q;

    always_comb begin
        int ci_eff;
        int rows;
        int segs;
        state_d  = state_q;
        c_d      = c_q;
        g_d      = g_q;
        r_d      = r_q;
        s_d      = s_q;
        w_cnt_d  = w_cnt_q;
        ky_d     = ky_q;
        d_d      = d_q;
        last_c_d = last_c_q;
        last_g_d = last_g_q;
        last_r_d = last_r_q;
        last_s_d = last_s_q;
        stride_d = stride_q;
        ci_eff   = cfg_group ? 1 : int'(cfg_ci);
        rows     = cfg_stride ? (int'(cfg_ifm_size) - 3) / 2 + 1 : int'(cfg_ifm_size) - 2;
        segs     = (int'(cfg_ifm_size) - 2) / TILE_LEN;
        case (state_q)
            S_IDLE: begin
                if (start_conv) begin
                    last_c_d = CHN_WIDTH'(ci_eff - 1);
                    last_g_d = CHN_OFT_WIDTH'(int'(cfg_co) / COL - 1);
                    last_r_d = FMS_WIDTH'(rows - 1);
                    last_s_d = FMS_WIDTH'(segs - 1);
                    stride_d = cfg_stride;
                    c_d      = '0;
                    g_d      = '0;
                    r_d      = '0;
                    s_d      = '0;
                    w_cnt_d  = '0;
                    ky_d     = '0;
                    d_d      = '0;
                    state_d  = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_cnt_q == RF_AWIDTH'(3*COL - 1)) begin
                    w_cnt_d = '0;
                    ky_d    = '0;
                    state_d = S_LOAD_I;
                end else begin
                    w_cnt_d = w_cnt_q + 1'b1;
                end
            end
            S_LOAD_I: begin
                if (ky_q == 2'd2) begin
                    ky_d = '0;
                    if (c_q == last_c_q) begin
                        d_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = S_LOAD_W;
                    end
                end else begin
                    ky_d = ky_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    d_d     = '0;
                    c_d     = '0;
                    state_d = S_LOAD_W;
                    if (s_q == last_s_q) begin
                        s_d = '0;
                        if (r_q == last_r_q) begin
                            r_d = '0;
                            if (g_q == last_g_q) state_d = S_DONE;
                            else                 g_d     = g_q + 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered images of the state being entered.
        wgt_read_d = (state_d == S_LOAD_W);
        ifm_read_d = (state_d == S_LOAD_I);
        done_d     = (state_d == S_DONE);
        valid_d    = (state_d == S_DRAIN);
    end

    always_comb begin
        rf_d = rf_q;
        if (state_q == S_LOAD_W) rf_d[w_cnt_q] = wgt_group;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            c_q        <= '0;
            g_q        <= '0;
            r_q        <= '0;
            s_q        <= '0;
            w_cnt_q    <= '0;
            ky_q       <= '0;
            d_q        <= '0;
            last_c_q   <= '0;
            last_g_q   <= '0;
            last_r_q   <= '0;
            last_s_q   <= '0;
            stride_q   <= 1'b0;
            wgt_read_q <= 1'b0;
            ifm_read_q <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            g_q        <= g_d;
            r_q        <= r_d;
            s_q        <= s_d;
            w_cnt_q    <= w_cnt_d;
            ky_q       <= ky_d;
            d_q        <= d_d;
            last_c_q   <= last_c_d;
            last_g_q   <= last_g_d;
            last_r_q   <= last_r_d;
            last_s_q   <= last_s_d;
            stride_q   <= stride_d;
            wgt_read_q <= wgt_read_d;
            ifm_read_q <= ifm_read_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign wgt_read     = wgt_read_q;
    assign ifm_read_out = ifm_read_q;
    assign conv_done    = done_q;

    genvar gi;
    generate
        for (gi = 0; gi < COL; gi++) begin : g_col
            logic signed [OFM_WIDTH-1:0] acc_q [TILE_LEN];
            logic signed [OFM_WIDTH-1:0] acc_d [TILE_LEN];
            logic [WGT_WIDTH-1:0]        w_row;
            logic signed [OFM_WIDTH-1:0] raw;

            assign w_row = rf_q[RF_AWIDTH'(3*gi + int'(ky_q))];

            always_comb begin
                for (int x = 0; x < TILE_LEN; x++) begin
                    acc_d[x] = acc_q[x];
                    if (state_q == S_LOAD_I)
                        acc_d[x] = acc_q[x] + row_mac(ifm_group, w_row, x);
                    else if (state_q == S_DRAIN && drain_last)
                        acc_d[x] = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int x = 0; x < TILE_LEN; x++) acc_q[x] <= '0;
                end else begin
                    for (int x = 0; x < TILE_LEN; x++) acc_q[x] <= acc_d[x];
                end
            end

            assign raw          = valid_q ? acc_q[drain_idx] : '0;
            assign sum_valid[gi] = valid_q;
`ifdef CONV2D_3X3_RELU_EN
            assign sum[gi] = raw[OFM_WIDTH-1] ? '0 : raw;
`else
            assign sum[gi] = raw;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_conv_2d_3x3.sv
// Self-checking bench for conv_2d_3x3: host streams from queues, direct-convolution model predicts sums.
`timescale 1ns/1ps
module tb_conv_2d_3x3;
    localparam int COL    = 4;
    localparam int OW     = 24;
    localparam int TL     = 8;
    localparam int BUDGET = 40000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           cfg_ci, cfg_co, cfg_ifm_size;
    logic                 cfg_stride, cfg_group, start_conv;
    logic [79:0]          ifm_group;
    logic [23:0]          wgt_group;
    logic                 ifm_read_out, wgt_read, conv_done;
    logic [COL-1:0]       sum_valid;
    logic signed [OW-1:0] sum [COL];

    always #5 clk = ~clk;

    conv_2d_3x3 dut (
        .clk(clk), .rst(rst), .cfg_ci(cfg_ci), .cfg_co(cfg_co), .cfg_stride(cfg_stride),
        .cfg_group(cfg_group), .cfg_ifm_size(cfg_ifm_size), .start_conv(start_conv),
        .ifm_group(ifm_group), .wgt_group(wgt_group), .ifm_read_out(ifm_read_out),
        .wgt_read(wgt_read), .conv_done(conv_done), .sum_valid(sum_valid), .sum(sum)
    );

    int vec = 0;
    int miss = 0;
    logic [23:0]          wgt_fifo [$];
    logic [79:0]          ifm_fifo [$];
    logic signed [OW-1:0] exp_fifo [$];
    int valid_cnt = 0;
    int done_cnt = 0;
    int mode = 0;
    int pconst = 0;
    int wconst = 0;
    int rnd_ifm [4][18][18];
    int rnd_wgt [8][4][3][3];

    function automatic int px(int c, int y, int x);
        if (mode == 0) return pconst;
        if (mode == 1) return x;
        return rnd_ifm[c][y][x];
    endfunction

    function automatic int wt(int o, int c, int ky, int kx);
        if (mode == 0) return wconst;
        if (mode == 1) return (ky == 0 && kx == 0) ? 1 : 0;
        return rnd_wgt[o][c][ky][kx];
    endfunction

    // Host: answer each strobe with the next pre-ordered word.
    always @(negedge clk) begin
        if (wgt_read) begin
            if (wgt_fifo.size() == 0) begin
                vec++; miss++;
                $display("FAIL wgt_underrun: wgt_read high, host has 0 words left, required >0");
            end else wgt_group = wgt_fifo.pop_front();
        end
        if (ifm_read_out) begin
            if (ifm_fifo.size() == 0) begin
                vec++; miss++;
                $display("FAIL ifm_underrun: ifm_read_out high, host has 0 words left, required >0");
            end else ifm_group = ifm_fifo.pop_front();
        end
    end

    // Compare process: every cycle with sum_valid is checked against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wgt_read && ifm_read_out) begin
                vec++; miss++;
                $display("FAIL strobe_excl: wgt_read=1 ifm_read_out=1, required not both");
            end
            if (sum_valid != '0) begin
                valid_cnt++;
                vec++;
                if (sum_valid != '1 || wgt_read || ifm_read_out) begin
                    miss++;
                    $display("FAIL valid_shape: sum_valid=%b wgt=%0b ifm=%0b, required 1111 0 0",
                             sum_valid, wgt_read, ifm_read_out);
                end
                for (int col = 0; col < COL; col++) begin
                    vec++;
                    if (exp_fifo.size() == 0) begin
                        miss++;
                        $display("FAIL sum_extra: col %0d got %0d, no result expected", col, sum[col]);
                    end else begin
                        logic signed [OW-1:0] e;
                        e = exp_fifo.pop_front();
                        if (sum[col] !== e) begin
                            miss++;
                            $display("FAIL sum: col %0d got %0d, required %0d", col, sum[col], e);
                        end
                    end
                end
            end
            if (conv_done) done_cnt++;
        end
    end

    task automatic build(input int ci, input int co, input int st, input int grp, input int s_sz,
                         output int tiles, output int nout, output int exp_cyc);
        int ci_eff, rows, segs, step;
        ci_eff = grp ? 1 : ci;
        step   = st ? 2 : 1;
        rows   = st ? (s_sz - 3) / 2 + 1 : s_sz - 2;
        segs   = (s_sz - 2) / TL;
        nout   = st ? TL / 2 : TL;
        tiles  = (co / COL) * rows * segs;
        exp_cyc = tiles * (ci_eff * (3*COL + 3) + nout) + 1;
        for (int g = 0; g < co / COL; g++)
            for (int r = 0; r < rows; r++)
                for (int s = 0; s < segs; s++) begin
                    for (int c = 0; c < ci_eff; c++) begin
                        for (int col = 0; col < COL; col++)
                            for (int ky = 0; ky < 3; ky++) begin
                                logic [23:0] w;
                                for (int kx = 0; kx < 3; kx++) w[kx*8 +: 8] = 8'(wt(g*COL+col, c, ky, kx));
                                wgt_fifo.push_back(w);
                            end
                        for (int ky = 0; ky < 3; ky++) begin
                            logic [79:0] iw;
                            for (int i = 0; i < TL + 2; i++) iw[i*8 +: 8] = 8'(px(c, step*r + ky, s*TL + i));
                            ifm_fifo.push_back(iw);
                        end
                    end
                    for (int j = 0; j < nout; j++)
                        for (int col = 0; col < COL; col++) begin
                            int acc;
                            int xo;
                            logic signed [OW-1:0] e;
                            acc = 0;
                            xo  = s*TL + step*j;
                            for (int c = 0; c < ci_eff; c++)
                                for (int ky = 0; ky < 3; ky++)
                                    for (int kx = 0; kx < 3; kx++)
                                        acc += px(c, step*r + ky, xo + kx) * wt(g*COL+col, c, ky, kx);
                            e = OW'(acc);
`ifdef CONV2D_3X3_RELU_EN
                            if (e < 0) e = '0;
`endif
                            exp_fifo.push_back(e);
                        end
                end
    endtask

    task automatic run_conv(input int ci, input int co, input int st, input int grp, input int s_sz,
                            input bit inject, input int pin_idx, input int pin_val, input string name);
        int tiles, nout, exp_cyc, cyc, tail_busy;
        bit injected;
        build(ci, co, st, grp, s_sz, tiles, nout, exp_cyc);
        if (pin_idx >= 0) begin
            vec++;
            if (int'(exp_fifo[pin_idx]) != pin_val) begin
                miss++;
                $display("FAIL model_pin %s: model gives %0d, required %0d", name, exp_fifo[pin_idx], pin_val);
            end
        end
        valid_cnt = 0;
        done_cnt  = 0;
        injected  = 0;
        @(negedge clk);
        cfg_ci = 8'(ci); cfg_co = 8'(co); cfg_stride = st[0]; cfg_group = grp[0];
        cfg_ifm_size = 8'(s_sz); start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        cyc = 1;
        while (!conv_done && cyc < BUDGET) begin
            if (start_conv) begin
                start_conv = 1'b0;
                cfg_stride = st[0];
            end else if (inject && !injected && sum_valid != '0) begin
                start_conv = 1'b1;
                cfg_stride = ~st[0];
                injected   = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start_conv = 1'b0;
        cfg_stride = st[0];
        vec++;
        if (cyc != exp_cyc) begin
            miss++;
            $display("FAIL done_cycle %s: conv_done at cycle %0d, required %0d", name, cyc, exp_cyc);
        end
        vec++;
        if (valid_cnt != tiles * nout) begin
            miss++;
            $display("FAIL valid_count %s: %0d valid cycles, required %0d", name, valid_cnt, tiles * nout);
        end
        vec++;
        if (exp_fifo.size() != 0 || wgt_fifo.size() != 0 || ifm_fifo.size() != 0) begin
            miss++;
            $display("FAIL leftover %s: exp=%0d wgt=%0d ifm=%0d, required 0 0 0", name,
                     exp_fifo.size(), wgt_fifo.size(), ifm_fifo.size());
        end
        tail_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (wgt_read || ifm_read_out || sum_valid != '0) tail_busy++;
        end
        vec++;
        if (done_cnt != 1 || tail_busy != 0) begin
            miss++;
            $display("FAIL idle_after %s: done pulses %0d busy cycles %0d, required 1 0", name, done_cnt, tail_busy);
        end
        $display("run %s: ci=%0d co=%0d stride=%0d group=%0d S=%0d cycles=%0d valids=%0d",
                 name, ci, co, st, grp, s_sz, cyc, valid_cnt);
        exp_fifo.delete(); wgt_fifo.delete(); ifm_fifo.delete();
    endtask

    task automatic check_idle(input string name);
        int bad;
        bad = (ifm_read_out || wgt_read || conv_done || sum_valid != '0) ? 1 : 0;
        for (int col = 0; col < COL; col++) if (sum[col] != '0) bad = 1;
        vec++;
        if (bad != 0) begin
            miss++;
            $display("FAIL %s: ifm=%0b wgt=%0b done=%0b valid=%b sum0=%0d, required all 0",
                     name, ifm_read_out, wgt_read, conv_done, sum_valid, sum[0]);
        end
    endtask

    task automatic randomize_data();
        for (int c = 0; c < 4; c++)
            for (int y = 0; y < 18; y++)
                for (int x = 0; x < 18; x++) rnd_ifm[c][y][x] = int'($urandom_range(0, 255)) - 128;
        for (int o = 0; o < 8; o++)
            for (int c = 0; c < 4; c++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) rnd_wgt[o][c][ky][kx] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic reset_test();
        int tiles, nout, exp_cyc, n, cyc, dones;
        mode = 2;
        randomize_data();
        build(2, 4, 0, 0, 10, tiles, nout, exp_cyc);
        @(negedge clk);
        cfg_ci = 8'd2; cfg_co = 8'd4; cfg_stride = 1'b0; cfg_group = 1'b0; cfg_ifm_size = 8'd10;
        start_conv = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        n = 0; cyc = 0;
        while (n < 7 && cyc < BUDGET) begin
            if (ifm_read_out) n++;
            if (n < 7) begin
                @(negedge clk);
                cyc++;
            end
        end
        vec++;
        if (n != 7) begin
            miss++;
            $display("FAIL reset_reach: saw %0d ifm reads, required 7", n);
        end
        rst = 1'b1;
        #1;
        check_idle("reset_mid_tile");
        exp_fifo.delete(); wgt_fifo.delete(); ifm_fifo.delete();
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (conv_done) dones++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (conv_done) dones++;
        end
        vec++;
        if (dones != 0) begin
            miss++;
            $display("FAIL reset_no_done: %0d conv_done pulses, required 0", dones);
        end
        check_idle("after_reset_release");
        $display("reset asserted on ifm read %0d, engine idle", n);
        run_conv(2, 4, 0, 0, 10, 0, -1, 0, "rerun_after_reset");
    endtask

    initial begin
        rst = 1'b1;
        cfg_ci = '0; cfg_co = '0; cfg_stride = 1'b0; cfg_group = 1'b0; cfg_ifm_size = '0;
        start_conv = 1'b0; ifm_group = '0; wgt_group = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle_after_release");

        mode = 0; pconst = 1; wconst = 1;
        run_conv(1, 4, 0, 0, 10, 0, 0, 9, "minimal");
        run_conv(1, 4, 0, 0, 10, 1, 0, 9, "ignored_start");

        mode = 0; pconst = 2; wconst = -1;
        run_conv(64, 8, 0, 0, 10, 0, 0, -1152, "multi_channel");

        mode = 1;
        run_conv(1, 4, 1, 0, 18, 0, 28, 14, "stride2");

        mode = 0; pconst = 127; wconst = 127;
        run_conv(255, 4, 1, 0, 10, 0, 5, 3461623, "wrap");

        mode = 2;
        randomize_data();
        run_conv(5, 4, 0, 1, 10, 0, -1, 0, "group_mode");
        for (int t = 0; t < 4; t++) begin
            int ci, co, st, grp, s_sz;
            randomize_data();
            ci   = int'($urandom_range(1, 4));
            co   = 4 * int'($urandom_range(1, 2));
            st   = int'($urandom_range(0, 1));
            grp  = int'($urandom_range(0, 1));
            s_sz = ($urandom_range(0, 1) == 1) ? 18 : 10;
            run_conv(ci, co, st, grp, s_sz, 0, -1, 0, "random");
        end

        reset_test();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
